// File: rtl/boot_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package boot_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CHK_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        HOLD,
        RUN,
        ERROR
    } boot_state_e;

endpackage

// File: rtl/imem_boot_loader.sv
// Streams a program image into instruction memory, verifies the trailing
// additive checksum and holds the core in reset until the image is good.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RST_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               core_reset,
    output logic               boot_done,
    output logic               boot_error,
    output logic [ADDR_W:0]    word_count
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned HOLD_W = $clog2(RST_HOLD + 1);

    boot_state_e        state_q, state_d;
    logic [CNT_W-1:0]   wc_q, wc_d;
    logic [CHK_W-1:0]   sum_q, sum_d;
    logic [CHK_W-1:0]   chk_q, chk_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               core_reset_q, core_reset_d;
    logic               boot_done_q, boot_done_d;
    logic               boot_error_q, boot_error_d;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        wc_d     = wc_q;
        sum_d    = sum_q;
        chk_d    = chk_q;
        hold_d   = hold_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;

        case (state_q)
            IDLE, RUN, ERROR: begin
                if (load_start) begin
                    state_d = LOAD;
                    wc_d    = '0;
                    sum_d   = '0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    if (in_last) begin
                        if (wc_q == '0) begin
                            state_d = ERROR;
                        end else begin
                            chk_d   = sum_q + in_data;
                            state_d = CHECK;
                        end
                    end else if (wc_q < CNT_W'(DEPTH)) begin
                        we_d    = 1'b1;
                        addr_d  = wc_q[ADDR_W-1:0];
                        wdata_d = in_data;
                        wc_d    = wc_q + CNT_W'(1);
                        sum_d   = sum_q + in_data;
                    end else begin
                        state_d = ERROR;
                    end
                end
            end
            CHECK: begin
                if (chk_q == '0) begin
                    state_d = HOLD;
                    hold_d  = HOLD_W'(RST_HOLD);
                end else begin
                    state_d = ERROR;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Status flags follow the state being entered so they are valid in its first cycle.
        core_reset_d = (state_d != RUN);
        boot_done_d  = (state_d == RUN);
        boot_error_d = (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            wc_q         <= '0;
            sum_q        <= '0;
            chk_q        <= '0;
            hold_q       <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            core_reset_q <= 1'b1;
            boot_done_q  <= 1'b0;
            boot_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            sum_q        <= sum_d;
            chk_q        <= chk_d;
            hold_q       <= hold_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            core_reset_q <= core_reset_d;
            boot_done_q  <= boot_done_d;
            boot_error_q <= boot_error_d;
        end
    end

    // Stream back-pressure is a direct decode of the load state.
    assign in_ready   = (state_q == LOAD);
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_reset = core_reset_q;
    assign boot_done  = boot_done_q;
    assign boot_error = boot_error_q;
    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed boot scenarios plus
// randomized images checked against an image-level reference model.
module tb_imem_boot_loader;
    import boot_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned RST_HOLD = 4;

    logic               clk        = 1'b0;
    logic               reset      = 1'b0;
    logic               load_start = 1'b0;
    logic               in_valid   = 1'b0;
    logic [INSTR_W-1:0] in_data    = '0;
    logic               in_last    = 1'b0;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               core_reset;
    logic               boot_done;
    logic               boot_error;
    logic [ADDR_W:0]    word_count;

    imem_boot_loader #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .RST_HOLD(RST_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load_start(load_start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .boot_done (boot_done),
        .boot_error(boot_error),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    logic [INSTR_W-1:0] img_q[$];
    logic [INSTR_W-1:0] exp_data_q[$];
    logic [ADDR_W-1:0]  exp_addr_q[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_core_reset"}, core_reset, 1);
        check({tag, "_in_ready"},   in_ready,   0);
        check({tag, "_imem_we"},    imem_we,    0);
        check({tag, "_boot_done"},  boot_done,  0);
        check({tag, "_boot_error"}, boot_error, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_imem_addr"},  imem_addr,  0);
        check({tag, "_imem_wdata"}, imem_wdata, 0);
    endtask

    // Every write the DUT issues must be the next one the image model predicts.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_we) begin
                if (exp_data_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL extra_write: addr 0x%0h data 0x%0h with no write expected", imem_addr, imem_wdata);
                end else begin
                    check("write_addr", imem_addr, exp_addr_q.pop_front());
                    check("write_data", imem_wdata, exp_data_q.pop_front());
                end
            end
            check("done_is_not_core_reset", boot_done, !core_reset);
        end
    end

    // Offers one beat after `gap` idle cycles; gives up if never accepted.
    task automatic send_beat(input logic [INSTR_W-1:0] d, input logic last, input int gap, output bit acc);
        acc = 0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = $urandom;
            in_last  = 1'($urandom_range(0, 1));
        end
        for (int w = 0; w < 4 && !acc; w++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = d;
            in_last  = last;
            if (in_ready) begin
                @(posedge clk);
                acc = 1;
            end
        end
    endtask

    // Loads img_q with checksum chk and checks the result; lat is the release latency.
    task automatic run_load(input logic [INSTR_W-1:0] chk, input int gap, output int lat);
        int n, nw, exp_acc, n_acc, t0;
        logic [INSTR_W-1:0] s, tot;
        bit ovf, ok, acc, stop;
        n = img_q.size();
        s = '0;
        foreach (img_q[i]) s = s + img_q[i];
        tot = s + chk;
        ovf = (n > int'(DEPTH));
        ok  = !ovf && (n > 0) && (tot == '0);
        nw  = ovf ? int'(DEPTH) : n;
        exp_acc = ovf ? int'(DEPTH) + 1 : n + 1;
        for (int i = 0; i < nw; i++) begin
            exp_addr_q.push_back(ADDR_W'(i));
            exp_data_q.push_back(img_q[i]);
        end
        lat = -1;

        @(negedge clk);
        load_start = 1'b1;
        t0 = int'(cyc) + 1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        check("start_core_reset", core_reset, 1);
        check("start_boot_done",  boot_done,  0);
        check("start_boot_error", boot_error, 0);
        check("start_word_count", word_count, 0);

        n_acc = 0;
        stop  = 0;
        for (int i = 0; i < n && !stop; i++) begin
            send_beat(img_q[i], 1'b0, gap, acc);
            if (acc) n_acc++;
            else stop = 1;
        end
        if (!stop) begin
            send_beat(chk, 1'b1, gap, acc);
            if (acc) n_acc++;
        end
        check("beats_accepted", n_acc, exp_acc);

        for (int w = 0; w < 60; w++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (!core_reset || boot_error) break;
        end
        if (ok) begin
            lat = int'(cyc) - t0;
            check("release_latency", lat, RST_HOLD + n + 3 + gap * (n + 1));
        end
        check("end_boot_done",  boot_done,  ok);
        check("end_boot_error", boot_error, !ok);
        check("end_core_reset", core_reset, !ok);
        check("end_word_count", word_count, nw);
        check("end_in_ready",   in_ready,   0);
        check("writes_pending", exp_data_q.size(), 0);
        exp_data_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic set_good_image();
        img_q.delete();
        img_q.push_back(32'h2008_0005);
        img_q.push_back(32'h2009_0003);
        img_q.push_back(32'h0109_5020);
    endtask

    initial begin
        int lat, n;
        bit acc;
        logic [INSTR_W-1:0] s, chk;

        // Asynchronous reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1 check_reset_vals("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_core_reset", core_reset, 1);

        set_good_image();
        run_load(32'hBEE5_AFD8, 0, lat);
        check("good_latency_literal", lat, 10);
        check("good_word_count_literal", word_count, 3);

        // Reboot from RUN with a bad checksum, then recover.
        run_load(32'h0000_0000, 0, lat);
        check("bad_chk_error_literal", boot_error, 1);
        repeat (3) @(negedge clk);
        check("error_holds_core", core_reset, 1);

        run_load(32'hBEE5_AFD8, 2, lat);
        check("gap_latency_literal", lat, 18);

        img_q.delete();
        for (int i = 0; i < 5; i++) img_q.push_back($urandom);
        run_load($urandom, 0, lat);
        check("ovf_word_count_literal", word_count, 4);

        img_q.delete();
        run_load(32'h0000_0000, 0, lat);

        // Abort a load with reset after two payload beats.
        set_good_image();
        run_load(32'hBEE5_AFD8, 0, lat);
        exp_addr_q.push_back(ADDR_W'(0)); exp_data_q.push_back(img_q[0]);
        exp_addr_q.push_back(ADDR_W'(1)); exp_data_q.push_back(img_q[1]);
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1 load_start = 1'b0;
        send_beat(img_q[0], 1'b0, 0, acc);
        send_beat(img_q[1], 1'b0, 0, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_vals("abort");
        check("abort_writes_seen", exp_data_q.size(), 0);
        exp_data_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_load(32'hBEE5_AFD8, 0, lat);

        // Randomized images: mostly good checksums, some corrupted, some overflow/empty.
        for (int t = 0; t < 16; t++) begin
            n = $urandom_range(0, 6);
            img_q.delete();
            s = '0;
            for (int i = 0; i < n; i++) begin
                img_q.push_back($urandom);
                s = s + img_q[i];
            end
            chk = ($urandom_range(0, 3) != 0) ? (32'd0 - s) : 32'($urandom);
            run_load(chk, $urandom_range(0, 2), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
